// File: rtl/hazard_fwd_ctrl_pkg.sv
// hazard_fwd_ctrl_pkg
// Shared definitions for the pipeline hazard/forwarding controller:
//   - forwarding mux select codes (operand muxes in EX)
//   - destination-register mux codes (regdst)
//   - slot_t, the per-stage record tracked for EX, MEM and WB
//   - slot_is_writer(), which decides whether a slot will really update the
//     register file
package hazard_fwd_ctrl_pkg;

  // Operand-forwarding mux select codes. Code 2'b11 is never produced.
  localparam logic [1:0] FWD_REG   = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b01;
  localparam logic [1:0] FWD_MEMWB = 2'b10;

  // Destination-register mux codes.
  localparam logic [1:0] REGDST_RT   = 2'b00;
  localparam logic [1:0] REGDST_RD   = 2'b01;
  localparam logic [1:0] REGDST_RA   = 2'b10;
  localparam logic [1:0] REGDST_ZERO = 2'b11;

  // Register-address width of the slot record. The top casts into and out of
  // this width so that its REG_W parameter stays the single point of control.
  localparam int SLOT_DEST_W = 5;

  typedef struct packed {
    logic                   valid;
    logic                   regwrite;
    logic                   memread;
    logic [SLOT_DEST_W-1:0] dest;
  } slot_t;

  // Writes to register 0 are discarded by the register file, so a slot
  // targeting r0 must never be treated as a forwarding source or hazard.
  function automatic logic slot_is_writer(input slot_t s);
    return s.valid && s.regwrite && (s.dest != '0);
  endfunction

endpackage

// File: rtl/hazard_fwd_ctrl_fwd_sel_calc.sv
// fwd_sel_calc
// Combinational per-operand forwarding comparator, evaluated while the
// consumer is still in ID (its result is registered into EX by the top).
// Ports:
//   uses_src   - consumer actually reads this operand
//   src        - consumer source register
//   ex_writer  - instruction currently in EX will write a nonzero register
//   ex_memread - that instruction is a load
//   ex_dest    - its destination register
//   mem_writer - instruction currently in MEM will write a nonzero register
//   mem_dest   - its destination register
//   sel        - forwarding select code for the consumer's EX cycle
module fwd_sel_calc
  import hazard_fwd_ctrl_pkg::*;
#(
  parameter int REG_W = 5
) (
  input  logic             uses_src,
  input  logic [REG_W-1:0] src,
  input  logic             ex_writer,
  input  logic             ex_memread,
  input  logic [REG_W-1:0] ex_dest,
  input  logic             mem_writer,
  input  logic [REG_W-1:0] mem_dest,
  output logic [1:0]       sel
);

  // The producer now in EX will sit in EX/MEM when the consumer reaches EX,
  // and the producer now in MEM will sit in MEM/WB. The nearer one holds the
  // newer value, so it is tested first. A load in EX has no result at the
  // EX/MEM register yet; the load-use stall covers that case instead.
  always_comb begin
    sel = FWD_REG;
    if (uses_src) begin
      if (ex_writer && !ex_memread && (ex_dest == src)) begin
        sel = FWD_EXMEM;
      end else if (mem_writer && (mem_dest == src)) begin
        sel = FWD_MEMWB;
      end
    end
  end

endmodule

// File: rtl/hazard_fwd_ctrl.sv
// hazard_fwd_ctrl
// Hazard detection and forwarding control for the 5-stage pipeline. Tracks
// the destination of each in-flight instruction through EX, MEM and WB,
// produces registered forwarding selects for the EX operand muxes, the
// registered destination-mux select, load-use stalls and a stall counter.
// Ports:
//   clk, reset          - clock and synchronous active-high reset
//   id_*                - decoded fields of the instruction in ID
//   flush               - taken branch; kills the ID instruction
//   stall               - freeze PC and IF/ID, bubble into EX
//   ex_fwd_a_sel/b_sel  - operand forwarding selects for the EX-stage muxes
//   ex_regdst_sel       - destination-mux select for the EX-stage instruction
//   wb_dest/wb_regwrite - register-file write port address and enable
//   stall_count         - saturating count of stall cycles
module hazard_fwd_ctrl
  import hazard_fwd_ctrl_pkg::*;
#(
  parameter int REG_W = 5,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic [REG_W-1:0] id_rd,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic             id_regwrite,
  input  logic             id_memread,
  input  logic [1:0]       id_regdst,
  input  logic             flush,
  output logic             stall,
  output logic [1:0]       ex_fwd_a_sel,
  output logic [1:0]       ex_fwd_b_sel,
  output logic [1:0]       ex_regdst_sel,
  output logic [REG_W-1:0] wb_dest,
  output logic             wb_regwrite,
  output logic [CNT_W-1:0] stall_count
);

  slot_t            ex_q, ex_d, mem_q, mem_d, wb_q, wb_d;
  logic [1:0]       fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;
  logic [1:0]       regdst_q, regdst_d;
  logic [CNT_W-1:0] stall_count_q, stall_count_d;

  logic [REG_W-1:0] id_dest, ex_dest, mem_dest;
  logic             ex_writer, mem_writer, hazard, advance;
  logic [1:0]       sel_a, sel_b;
  logic             unused_wb_memread;

  // Resolve the ID instruction's destination with the same code that later
  // steers the destination mux, so tracking and datapath always agree.
  always_comb begin
    id_dest = '0;
    case (id_regdst)
      REGDST_RT:   id_dest = id_rt;
      REGDST_RD:   id_dest = id_rd;
      REGDST_RA:   id_dest = REG_W'(31);
      REGDST_ZERO: id_dest = '0;
      default:     id_dest = '0;
    endcase
  end

  assign ex_dest    = REG_W'(ex_q.dest);
  assign mem_dest   = REG_W'(mem_q.dest);
  assign ex_writer  = slot_is_writer(ex_q);
  assign mem_writer = slot_is_writer(mem_q);

  // A load in EX whose result the ID instruction needs cannot be forwarded
  // in time; one bubble moves the load to MEM where MEM/WB can supply it.
  assign hazard = id_valid && ex_writer && ex_q.memread &&
                  ((id_uses_rs && (id_rs == ex_dest)) ||
                   (id_uses_rt && (id_rt == ex_dest)));

  // A taken branch kills the consumer, so there is nothing left to stall.
  assign stall   = hazard && !flush;
  assign advance = id_valid && !flush && !hazard;

  fwd_sel_calc #(.REG_W(REG_W)) u_fwd_a (
    .uses_src   (id_uses_rs),
    .src        (id_rs),
    .ex_writer  (ex_writer),
    .ex_memread (ex_q.memread),
    .ex_dest    (ex_dest),
    .mem_writer (mem_writer),
    .mem_dest   (mem_dest),
    .sel        (sel_a)
  );

  fwd_sel_calc #(.REG_W(REG_W)) u_fwd_b (
    .uses_src   (id_uses_rt),
    .src        (id_rt),
    .ex_writer  (ex_writer),
    .ex_memread (ex_q.memread),
    .ex_dest    (ex_dest),
    .mem_writer (mem_writer),
    .mem_dest   (mem_dest),
    .sel        (sel_b)
  );

  // Next-state for the slot pipeline and the EX-stage selects. MEM and WB
  // always shift; EX either takes the ID instruction with its selects or
  // becomes a bubble with all selects at 00. The stall counter sticks at
  // all-ones instead of wrapping.
  always_comb begin
    mem_d         = ex_q;
    wb_d          = mem_q;
    ex_d          = '0;
    fwd_a_d       = FWD_REG;
    fwd_b_d       = FWD_REG;
    regdst_d      = REGDST_RT;
    stall_count_d = stall_count_q;

    if (advance) begin
      ex_d.valid    = 1'b1;
      ex_d.regwrite = id_regwrite;
      ex_d.memread  = id_memread;
      ex_d.dest     = SLOT_DEST_W'(id_dest);
      fwd_a_d       = sel_a;
      fwd_b_d       = sel_b;
      regdst_d      = id_regdst;
    end

    if (stall && (stall_count_q != '1)) begin
      stall_count_d = stall_count_q + 1'b1;
    end
  end

  // State registers with synchronous reset; reset empties every slot so no
  // hazard or forwarding can fire in the following cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      ex_q          <= '0;
      mem_q         <= '0;
      wb_q          <= '0;
      fwd_a_q       <= FWD_REG;
      fwd_b_q       <= FWD_REG;
      regdst_q      <= REGDST_RT;
      stall_count_q <= '0;
    end else begin
      ex_q          <= ex_d;
      mem_q         <= mem_d;
      wb_q          <= wb_d;
      fwd_a_q       <= fwd_a_d;
      fwd_b_q       <= fwd_b_d;
      regdst_q      <= regdst_d;
      stall_count_q <= stall_count_d;
    end
  end

  // The load flag has no consumer once an instruction reaches WB.
  assign unused_wb_memread = wb_q.memread;

  assign ex_fwd_a_sel  = fwd_a_q;
  assign ex_fwd_b_sel  = fwd_b_q;
  assign ex_regdst_sel = regdst_q;
  assign wb_dest       = REG_W'(wb_q.dest);
  assign wb_regwrite   = wb_q.valid && wb_q.regwrite;
  assign stall_count   = stall_count_q;

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// tb_hazard_fwd_ctrl
// Self-checking bench for hazard_fwd_ctrl. Each scenario task drives a short
// instruction sequence into ID, pushes the expected EX-cycle selects onto a
// scoreboard queue as each instruction is driven, and pops/compares them one
// cycle later. The stall counter runs with CNT_W = 4 to reach saturation.
module tb_hazard_fwd_ctrl;

  localparam int REG_W = 5;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             id_valid;
  logic [REG_W-1:0] id_rs, id_rt, id_rd;
  logic             id_uses_rs, id_uses_rt, id_regwrite, id_memread;
  logic [1:0]       id_regdst;
  logic             flush;
  logic             stall;
  logic [1:0]       ex_fwd_a_sel, ex_fwd_b_sel, ex_regdst_sel;
  logic [REG_W-1:0] wb_dest;
  logic             wb_regwrite;
  logic [CNT_W-1:0] stall_count;

  int               n_tests = 0;
  int               n_fail  = 0;
  logic [CNT_W-1:0] exp_count = '0;

  typedef struct {
    logic [1:0] a;
    logic [1:0] b;
    logic [1:0] rd;
  } exp_t;

  exp_t sb[$];

  typedef struct {
    logic       v;
    logic [4:0] rs, rt, rd;
    logic       urs, urt, rw, mr;
    logic [1:0] rdst;
    logic       fl;
    logic       st;
    logic [1:0] a, b, erd;
    logic       chk_wb;
    logic [4:0] wbd;
    logic       wbw;
  } stim_t;

  hazard_fwd_ctrl #(.REG_W(REG_W), .CNT_W(CNT_W)) dut (
    .clk           (clk),
    .reset         (reset),
    .id_valid      (id_valid),
    .id_rs         (id_rs),
    .id_rt         (id_rt),
    .id_rd         (id_rd),
    .id_uses_rs    (id_uses_rs),
    .id_uses_rt    (id_uses_rt),
    .id_regwrite   (id_regwrite),
    .id_memread    (id_memread),
    .id_regdst     (id_regdst),
    .flush         (flush),
    .stall         (stall),
    .ex_fwd_a_sel  (ex_fwd_a_sel),
    .ex_fwd_b_sel  (ex_fwd_b_sel),
    .ex_regdst_sel (ex_regdst_sel),
    .wb_dest       (wb_dest),
    .wb_regwrite   (wb_regwrite),
    .stall_count   (stall_count)
  );

  // Free-running clock, 10 time units per period.
  always #5 clk = ~clk;

  function automatic stim_t mk(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                               input logic [4:0] rd, input logic urs, input logic urt,
                               input logic rw, input logic mr, input logic [1:0] rdst,
                               input logic fl, input logic st, input logic [1:0] a,
                               input logic [1:0] b, input logic [1:0] erd);
    stim_t s;
    s.v = v; s.rs = rs; s.rt = rt; s.rd = rd;
    s.urs = urs; s.urt = urt; s.rw = rw; s.mr = mr;
    s.rdst = rdst; s.fl = fl; s.st = st;
    s.a = a; s.b = b; s.erd = erd;
    s.chk_wb = 1'b0; s.wbd = '0; s.wbw = 1'b0;
    return s;
  endfunction

  function automatic stim_t with_wb(input stim_t s, input logic [4:0] d, input logic w);
    stim_t r;
    r = s;
    r.chk_wb = 1'b1;
    r.wbd = d;
    r.wbw = w;
    return r;
  endfunction

  // R-type rd = rs op rt, no stall expected.
  function automatic stim_t r_type(input logic [4:0] rs, input logic [4:0] rt,
                                   input logic [4:0] rd, input logic [1:0] a,
                                   input logic [1:0] b);
    return mk(1'b1, rs, rt, rd, 1'b1, 1'b1, 1'b1, 1'b0, 2'b01, 1'b0, 1'b0, a, b, 2'b01);
  endfunction

  // lw rt, imm(rs)
  function automatic stim_t load(input logic [4:0] rs, input logic [4:0] rt,
                                 input logic [1:0] a);
    return mk(1'b1, rs, rt, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0, a, 2'b00, 2'b00);
  endfunction

  function automatic stim_t nop();
    return mk(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0,
              2'b00, 2'b00, 2'b00);
  endfunction

  task automatic apply_id(input stim_t s);
    id_valid    = s.v;
    id_rs       = s.rs;
    id_rt       = s.rt;
    id_rd       = s.rd;
    id_uses_rs  = s.urs;
    id_uses_rt  = s.urt;
    id_regwrite = s.rw;
    id_memread  = s.mr;
    id_regdst   = s.rdst;
    flush       = s.fl;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    apply_id(nop());
    tick();
    tick();
    reset = 1'b0;
    #1;
    n_tests++;
    if ({stall, ex_fwd_a_sel, ex_fwd_b_sel, ex_regdst_sel} !== 7'b0) begin
      n_fail++;
      $display("[TB] FAIL reset_selects: got stall=%b a=%b b=%b rd=%b, want all 0",
               stall, ex_fwd_a_sel, ex_fwd_b_sel, ex_regdst_sel);
    end
    n_tests++;
    if ({wb_regwrite, wb_dest} !== 6'b0) begin
      n_fail++;
      $display("[TB] FAIL reset_wb: got we=%b dest=%0d, want 0/0", wb_regwrite, wb_dest);
    end
    n_tests++;
    if (stall_count !== 4'd0) begin
      n_fail++;
      $display("[TB] FAIL reset_count: got %0d, want 0", stall_count);
    end
  endtask

  task automatic test_back_to_back();
    stim_t s[$];
    exp_t  p, e;
    s.push_back(nop()); s.push_back(nop()); s.push_back(nop());
    s.push_back(r_type(5'd1, 5'd2, 5'd3, 2'b00, 2'b00));
    s.push_back(r_type(5'd3, 5'd1, 5'd4, 2'b01, 2'b00));
    s.push_back(with_wb(nop(), 5'd3, 1'b1));
    s.push_back(with_wb(nop(), 5'd4, 1'b1));
    s.push_back(with_wb(nop(), 5'd0, 1'b0));
    foreach (s[i]) begin
      apply_id(s[i]);
      p.a = s[i].a; p.b = s[i].b; p.rd = s[i].erd;
      sb.push_back(p);
      if (s[i].st) exp_count = (exp_count == '1) ? exp_count : exp_count + 1'b1;
      #1;
      n_tests++;
      if (stall !== s[i].st) begin
        n_fail++;
        $display("[TB] FAIL back_to_back[%0d] stall: got %b want %b", i, stall, s[i].st);
      end
      tick();
      e = sb.pop_front();
      n_tests++;
      if ({ex_fwd_a_sel, ex_fwd_b_sel, ex_regdst_sel} !== {e.a, e.b, e.rd}) begin
        n_fail++;
        $display("[TB] FAIL back_to_back[%0d] sel: got a=%b b=%b rd=%b want a=%b b=%b rd=%b",
                 i, ex_fwd_a_sel, ex_fwd_b_sel, ex_regdst_sel, e.a, e.b, e.rd);
      end
      if (s[i].chk_wb) begin
        n_tests++;
        if ({wb_regwrite, wb_dest} !== {s[i].wbw, s[i].wbd}) begin
          n_fail++;
          $display("[TB] FAIL back_to_back[%0d] wb: got we=%b dest=%0d want we=%b dest=%0d",
                   i, wb_regwrite, wb_dest, s[i].wbw, s[i].wbd);
        end
      end
    end
  endtask

  task automatic test_one_gap();
    stim_t s[$];
    exp_t  p, e;
    s.push_back(nop()); s.push_back(nop()); s.push_back(nop());
    s.push_back(r_type(5'd1, 5'd2, 5'd5, 2'b00, 2'b00));
    s.push_back(nop());
    s.push_back(r_type(5'd4, 5'd5, 5'd6, 2'b00, 2'b10));
    s.push_back(r_type(5'd1, 5'd2, 5'd5, 2'b00, 2'b00));
    s.push_back(r_type(5'd2, 5'd3, 5'd5, 2'b00, 2'b00));
    s.push_back(r_type(5'd8, 5'd5, 5'd7, 2'b00, 2'b01));
    s.push_back(r_type(5'd5, 5'd9, 5'd10, 2'b10, 2'b00));
    foreach (s[i]) begin
      apply_id(s[i]);
      p.a = s[i].a; p.b = s[i].b; p.rd = s[i].erd;
      sb.push_back(p);
      if (s[i].st) exp_count = (exp_count == '1) ? exp_count : exp_count + 1'b1;
      #1;
      n_tests++;
      if (stall !== s[i].st) begin
        n_fail++;
        $display("[TB] FAIL one_gap[%0d] stall: got %b want %b", i, stall, s[i].st);
      end
      tick();
      e = sb.pop_front();
      n_tests++;
      if ({ex_fwd_a_sel, ex_fwd_b_sel, ex_regdst_sel} !== {e.a, e.b, e.rd}) begin
        n_fail++;
        $display("[TB] FAIL one_gap[%0d] sel: got a=%b b=%b rd=%b want a=%b b=%b rd=%b",
                 i, ex_fwd_a_sel, ex_fwd_b_sel, ex_regdst_sel, e.a, e.b, e.rd);
      end
    end
  endtask

  task automatic test_load_use();
    stim_t s[$];
    exp_t  p, e;
    s.push_back(nop()); s.push_back(nop()); s.push_back(nop());
    s.push_back(load(5'd1, 5'd7, 2'b00));
    s.push_back(mk(1'b1, 5'd7, 5'd2, 5'd8, 1'b1, 1'b1, 1'b1, 1'b0, 2'b01, 1'b0, 1'b1,
                   2'b00, 2'b00, 2'b00));
    s.push_back(r_type(5'd7, 5'd2, 5'd8, 2'b10, 2'b00));
    s.push_back(load(5'd1, 5'd9, 2'b00));
    s.push_back(mk(1'b1, 5'd3, 5'd9, 5'd10, 1'b1, 1'b1, 1'b1, 1'b0, 2'b01, 1'b0, 1'b1,
                   2'b00, 2'b00, 2'b00));
    s.push_back(r_type(5'd3, 5'd9, 5'd10, 2'b00, 2'b10));
    s.push_back(nop());
    foreach (s[i]) begin
      apply_id(s[i]);
      p.a = s[i].a; p.b = s[i].b; p.rd = s[i].erd;
      sb.push_back(p);
      if (s[i].st) exp_count = (exp_count == '1) ? exp_count : exp_count + 1'b1;
      #1;
      n_tests++;
      if (stall !== s[i].st) begin
        n_fail++;
        $display("[TB] FAIL load_use[%0d] stall: got %b want %b", i, stall, s[i].st);
      end
      tick();
      e = sb.pop_front();
      n_tests++;
      if ({ex_fwd_a_sel, ex_fwd_b_sel, ex_regdst_sel} !== {e.a, e.b, e.rd}) begin
        n_fail++;
        $display("[TB] FAIL load_use[%0d] sel: got a=%b b=%b rd=%b want a=%b b=%b rd=%b",
                 i, ex_fwd_a_sel, ex_fwd_b_sel, ex_regdst_sel, e.a, e.b, e.rd);
      end
    end
    n_tests++;
    if (stall_count !== exp_count) begin
      n_fail++;
      $display("[TB] FAIL load_use count: got %0d want %0d", stall_count, exp_count);
    end
  endtask

  task automatic test_reg0_ra();
    stim_t s[$];
    exp_t  p, e;
    s.push_back(nop()); s.push_back(nop()); s.push_back(nop());
    s.push_back(r_type(5'd1, 5'd2, 5'd0, 2'b00, 2'b00));
    s.push_back(r_type(5'd0, 5'd0, 5'd9, 2'b00, 2'b00));
    s.push_back(r_type(5'd0, 5'd0, 5'd10, 2'b00, 2'b00));
    s.push_back(mk(1'b1, 5'd0, 5'd4, 5'd4, 1'b0, 1'b0, 1'b1, 1'b0, 2'b11, 1'b0, 1'b0,
                   2'b00, 2'b00, 2'b11));
    s.push_back(mk(1'b1, 5'd4, 5'd0, 5'd11, 1'b1, 1'b0, 1'b1, 1'b0, 2'b01, 1'b0, 1'b0,
                   2'b00, 2'b00, 2'b01));
    s.push_back(with_wb(mk(1'b1, 5'd0, 5'd4, 5'd4, 1'b0, 1'b0, 1'b1, 1'b0, 2'b10, 1'b0,
                           1'b0, 2'b00, 2'b00, 2'b10), 5'd0, 1'b1));
    s.push_back(mk(1'b1, 5'd31, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0,
                   2'b01, 2'b00, 2'b00));
    s.push_back(with_wb(nop(), 5'd31, 1'b1));
    foreach (s[i]) begin
      apply_id(s[i]);
      p.a = s[i].a; p.b = s[i].b; p.rd = s[i].erd;
      sb.push_back(p);
      if (s[i].st) exp_count = (exp_count == '1) ? exp_count : exp_count + 1'b1;
      #1;
      n_tests++;
      if (stall !== s[i].st) begin
        n_fail++;
        $display("[TB] FAIL reg0_ra[%0d] stall: got %b want %b", i, stall, s[i].st);
      end
      tick();
      e = sb.pop_front();
      n_tests++;
      if ({ex_fwd_a_sel, ex_fwd_b_sel, ex_regdst_sel} !== {e.a, e.b, e.rd}) begin
        n_fail++;
        $display("[TB] FAIL reg0_ra[%0d] sel: got a=%b b=%b rd=%b want a=%b b=%b rd=%b",
                 i, ex_fwd_a_sel, ex_fwd_b_sel, ex_regdst_sel, e.a, e.b, e.rd);
      end
      if (s[i].chk_wb) begin
        n_tests++;
        if ({wb_regwrite, wb_dest} !== {s[i].wbw, s[i].wbd}) begin
          n_fail++;
          $display("[TB] FAIL reg0_ra[%0d] wb: got we=%b dest=%0d want we=%b dest=%0d",
                   i, wb_regwrite, wb_dest, s[i].wbw, s[i].wbd);
        end
      end
    end
  endtask

  task automatic test_flush_hazard();
    stim_t s[$];
    exp_t  p, e;
    s.push_back(nop()); s.push_back(nop()); s.push_back(nop());
    s.push_back(load(5'd1, 5'd7, 2'b00));
    s.push_back(mk(1'b1, 5'd7, 5'd2, 5'd8, 1'b1, 1'b1, 1'b1, 1'b0, 2'b01, 1'b1, 1'b0,
                   2'b00, 2'b00, 2'b00));
    s.push_back(with_wb(nop(), 5'd7, 1'b1));
    s.push_back(with_wb(nop(), 5'd0, 1'b0));
    foreach (s[i]) begin
      apply_id(s[i]);
      p.a = s[i].a; p.b = s[i].b; p.rd = s[i].erd;
      sb.push_back(p);
      if (s[i].st) exp_count = (exp_count == '1) ? exp_count : exp_count + 1'b1;
      #1;
      n_tests++;
      if (stall !== s[i].st) begin
        n_fail++;
        $display("[TB] FAIL flush_hazard[%0d] stall: got %b want %b", i, stall, s[i].st);
      end
      tick();
      e = sb.pop_front();
      n_tests++;
      if ({ex_fwd_a_sel, ex_fwd_b_sel, ex_regdst_sel} !== {e.a, e.b, e.rd}) begin
        n_fail++;
        $display("[TB] FAIL flush_hazard[%0d] sel: got a=%b b=%b rd=%b want a=%b b=%b rd=%b",
                 i, ex_fwd_a_sel, ex_fwd_b_sel, ex_regdst_sel, e.a, e.b, e.rd);
      end
      if (s[i].chk_wb) begin
        n_tests++;
        if ({wb_regwrite, wb_dest} !== {s[i].wbw, s[i].wbd}) begin
          n_fail++;
          $display("[TB] FAIL flush_hazard[%0d] wb: got we=%b dest=%0d want we=%b dest=%0d",
                   i, wb_regwrite, wb_dest, s[i].wbw, s[i].wbd);
        end
      end
    end
    n_tests++;
    if (stall_count !== exp_count) begin
      n_fail++;
      $display("[TB] FAIL flush_hazard count: got %0d want %0d", stall_count, exp_count);
    end
  endtask

  task automatic test_reset_mid();
    // add r3 moves toward WB while a load-use stall is pending in ID.
    apply_id(r_type(5'd1, 5'd2, 5'd3, 2'b00, 2'b00));
    tick();
    apply_id(load(5'd1, 5'd7, 2'b00));
    tick();
    apply_id(mk(1'b1, 5'd7, 5'd2, 5'd8, 1'b1, 1'b1, 1'b1, 1'b0, 2'b01, 1'b0, 1'b1,
                2'b00, 2'b00, 2'b00));
    #1;
    n_tests++;
    if (stall !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL reset_mid pending stall: got %b want 1", stall);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    sb.delete();
    exp_count = '0;
    #1;
    n_tests++;
    if ({stall, ex_fwd_a_sel, ex_fwd_b_sel, ex_regdst_sel} !== 7'b0) begin
      n_fail++;
      $display("[TB] FAIL reset_mid selects: got stall=%b a=%b b=%b rd=%b, want all 0",
               stall, ex_fwd_a_sel, ex_fwd_b_sel, ex_regdst_sel);
    end
    n_tests++;
    if ({wb_regwrite, wb_dest} !== 6'b0) begin
      n_fail++;
      $display("[TB] FAIL reset_mid wb: got we=%b dest=%0d, want 0/0", wb_regwrite, wb_dest);
    end
    n_tests++;
    if (stall_count !== exp_count) begin
      n_fail++;
      $display("[TB] FAIL reset_mid count: got %0d want %0d", stall_count, exp_count);
    end
    apply_id(nop());
    tick();
  endtask

  task automatic test_stall_saturation();
    for (int k = 1; k <= 17; k++) begin
      apply_id(load(5'd1, 5'd7, 2'b00));
      tick();
      apply_id(mk(1'b1, 5'd7, 5'd2, 5'd8, 1'b1, 1'b1, 1'b1, 1'b0, 2'b01, 1'b0, 1'b1,
                  2'b00, 2'b00, 2'b00));
      #1;
      n_tests++;
      if (stall !== 1'b1) begin
        n_fail++;
        $display("[TB] FAIL saturation[%0d] stall: got %b want 1", k, stall);
      end
      exp_count = (exp_count == '1) ? exp_count : exp_count + 1'b1;
      tick();
      apply_id(r_type(5'd7, 5'd2, 5'd8, 2'b10, 2'b00));
      tick();
      n_tests++;
      if (stall_count !== exp_count) begin
        n_fail++;
        $display("[TB] FAIL saturation[%0d] count: got %0d want %0d", k, stall_count, exp_count);
      end
    end
    n_tests++;
    if (stall_count !== 4'd15) begin
      n_fail++;
      $display("[TB] FAIL saturation final: got %0d want 15", stall_count);
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_one_gap();
    test_load_use();
    test_reg0_ra();
    test_flush_hazard();
    test_reset_mid();
    test_stall_saturation();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
